// File: rtl/sound_pkg.sv
// Shared types and the constant segment table for the buzzer effect sequencer.
package sound_pkg;

   typedef enum logic [1:0] {
      SND_NONE = 2'd0,
      SND_JUMP = 2'd1,
      SND_MILE = 2'd2,
      SND_OVER = 2'd3
   } snd_e;

   typedef struct packed {
      logic [19:0] hp;
      logic [8:0]  count;
      logic        is_tone;
   } seg_t;

   localparam int SEG_MAX = 3;

   localparam seg_t SEG_NULL = '{hp: 20'd2, count: 9'd1, is_tone: 1'b0};

   // Rows are indexed by snd_e; the fourth column pads the 2-bit segment index.
   localparam seg_t SEG_TBL [4][4] = '{
      '{SEG_NULL, SEG_NULL, SEG_NULL, SEG_NULL},
      '{'{20'd97276, 9'd38, 1'b1}, SEG_NULL, SEG_NULL, SEG_NULL},
      '{'{20'd97276, 9'd81, 1'b1}, '{20'd65189, 9'd342, 1'b1}, SEG_NULL, SEG_NULL},
      '{'{20'd781250, 9'd5, 1'b1}, '{20'd781250, 9'd4, 1'b0}, '{20'd781250, 9'd10, 1'b1}, SEG_NULL}
   };

   localparam logic [1:0] SEG_CNT [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

   function automatic logic [19:0] eff_hp(input logic [19:0] hp, input int shift);
      logic [19:0] s;
      s = hp >> shift;
      return (s < 20'd2) ? 20'd2 : s;
   endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave half-period counter: ticks on the last cycle of each half-period
// and toggles phase; restart forces a clean start of a new segment.
module tone_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] hp,
   input  logic        restart,
   input  logic        en,
   output logic        phase,
   output logic        tick
);
   logic [19:0] cnt;

   assign tick = en & (cnt == hp - 20'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (restart) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (en) begin
         if (tick) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end
   end

endmodule

// File: rtl/sound_sequencer.sv
// Buzzer effect sequencer: edge-detects game events, arbitrates them by priority
// and walks each effect's tone/rest segment table through one tone generator.
module sound_sequencer
   import sound_pkg::*;
#(
   parameter int HP_SHIFT = 0,
   parameter int HW_W     = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jumping,
   input  logic       milestone,
   input  logic       over,
   input  logic       mute,
   output logic       buzzer,
   output logic       busy,
   output logic [1:0] cur_snd
);
   logic            jump_q, mile_q, over_q;
   logic            req_j, req_m, req_o;
   snd_e            cur, pending, req_hi, req_2nd;
   logic [1:0]      seg_idx;
   logic [HW_W-1:0] wave_cnt, last_wave;
   logic [19:0]     seg_hp;
   logic [8:0]      seg_count;
   logic            phase, tick;

   snd_e            cur_n, pend_n;
   logic [1:0]      seg_n;
   logic [HW_W-1:0] wave_n;
   logic            busy_n, restart, tone_n;

   assign req_j     = jumping & ~jump_q;
   assign req_m     = milestone & ~mile_q;
   assign req_o     = over & ~over_q;
   assign seg_hp    = eff_hp(SEG_TBL[cur][seg_idx].hp, HP_SHIFT);
   assign seg_count = SEG_TBL[cur][seg_idx].count;
   assign last_wave = HW_W'(seg_count - 9'd1);
   assign tone_n    = SEG_TBL[cur_n][seg_n].is_tone;
   assign cur_snd   = cur;

   always_comb begin
      req_hi  = SND_NONE;
      req_2nd = SND_NONE;
      if (req_o) begin
         req_hi  = SND_OVER;
         req_2nd = req_m ? SND_MILE : (req_j ? SND_JUMP : SND_NONE);
      end else if (req_m) begin
         req_hi  = SND_MILE;
         req_2nd = req_j ? SND_JUMP : SND_NONE;
      end else if (req_j) begin
         req_hi = SND_JUMP;
      end
   end

   // Segment bookkeeping first, so a same-cycle request is arbitrated against
   // whatever effect is about to be playing.
   always_comb begin
      cur_n   = cur;
      pend_n  = pending;
      seg_n   = seg_idx;
      wave_n  = wave_cnt;
      busy_n  = busy;
      restart = 1'b0;
      if (busy && tick) begin
         if (wave_cnt == last_wave) begin
            wave_n = '0;
            if (seg_idx + 2'd1 < SEG_CNT[cur]) begin
               seg_n   = seg_idx + 2'd1;
               restart = 1'b1;
            end else if (pending != SND_NONE) begin
               cur_n   = pending;
               pend_n  = SND_NONE;
               seg_n   = 2'd0;
               restart = 1'b1;
            end else begin
               cur_n  = SND_NONE;
               seg_n  = 2'd0;
               busy_n = 1'b0;
            end
         end else begin
            wave_n = wave_cnt + HW_W'(1);
         end
      end
      if (req_hi != SND_NONE) begin
         if (req_hi >= cur_n) begin
            if (cur_n == SND_NONE) pend_n = req_2nd;
            if (req_hi == SND_OVER) pend_n = SND_NONE;
            cur_n   = req_hi;
            seg_n   = 2'd0;
            wave_n  = '0;
            busy_n  = 1'b1;
            restart = 1'b1;
         end else if (req_hi > pend_n) begin
            pend_n = req_hi;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         jump_q   <= 1'b0;
         mile_q   <= 1'b0;
         over_q   <= 1'b0;
         cur      <= SND_NONE;
         pending  <= SND_NONE;
         seg_idx  <= 2'd0;
         wave_cnt <= '0;
         busy     <= 1'b0;
         buzzer   <= 1'b0;
      end else begin
         jump_q   <= jumping;
         mile_q   <= milestone;
         over_q   <= over;
         cur      <= cur_n;
         pending  <= pend_n;
         seg_idx  <= seg_n;
         wave_cnt <= wave_n;
         busy     <= busy_n;
         // Registered from the next phase so the pin lines up with the segment.
         buzzer   <= ~restart & (phase ^ tick) & tone_n & busy_n & ~mute;
      end
   end

   tone_gen u_tone (
      .clk     (clk),
      .rst     (rst),
      .hp      (seg_hp),
      .restart (restart),
      .en      (busy),
      .phase   (phase),
      .tick    (tick)
   );

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed event scenarios plus random event levels,
// checked every cycle against a duration/offset model of each effect.
`timescale 1ns/1ps
module tb_sound_sequencer;
   localparam int HP_SHIFT = 10;

   logic       clk;
   logic       rst;
   logic       jumping, milestone, over, mute;
   logic       buzzer, busy;
   logic [1:0] cur_snd;

   int total, bad;
   logic [3:0] exp_q[$];

   int m_cur, m_pend, m_start, cyc;
   bit m_jq, m_mq, m_oq;

   int last_run[4];
   int run_len;
   logic [1:0] prev_snd;
   logic [3:0] got_v, want_v;
   bit lv_j, lv_m, lv_o, lv_mu;

   sound_sequencer #(.HP_SHIFT(HP_SHIFT), .HW_W(9)) dut (
      .clk       (clk),
      .rst       (rst),
      .jumping   (jumping),
      .milestone (milestone),
      .over      (over),
      .mute      (mute),
      .buzzer    (buzzer),
      .busy      (busy),
      .cur_snd   (cur_snd)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got=running want=finished");
      $fatal(1, "watchdog");
   end

   // reference model: effect tables straight from the sound definitions
   function automatic int hp_of(input int e, input int s);
      int raw;
      case (e)
         1:       raw = 97276;
         2:       raw = (s == 0) ? 97276 : 65189;
         3:       raw = 781250;
         default: raw = 0;
      endcase
      raw = raw >> HP_SHIFT;
      return (raw < 2) ? 2 : raw;
   endfunction

   function automatic int cnt_of(input int e, input int s);
      int c;
      case (e)
         1:       c = 38;
         2:       c = (s == 0) ? 81 : 342;
         3:       c = (s == 0) ? 5 : ((s == 1) ? 4 : 10);
         default: c = 0;
      endcase
      return c;
   endfunction

   function automatic bit tone_of(input int e, input int s);
      return !(e == 3 && s == 1);
   endfunction

   function automatic int nseg(input int e);
      int n;
      case (e)
         1:       n = 1;
         2:       n = 2;
         3:       n = 3;
         default: n = 0;
      endcase
      return n;
   endfunction

   function automatic int dur(input int e);
      int d;
      d = 0;
      for (int s = 0; s < nseg(e); s++) d += hp_of(e, s) * cnt_of(e, s);
      return d;
   endfunction

   // buzzer level el cycles into effect e: odd half-waves of tone segments are high
   function automatic bit exp_buzz(input int e, input int el);
      int off, len;
      bit res, done;
      off = 0; res = 1'b0; done = 1'b0;
      for (int s = 0; s < nseg(e); s++) begin
         len = hp_of(e, s) * cnt_of(e, s);
         if (!done && el < off + len) begin
            res  = tone_of(e, s) && ((((el - off) / hp_of(e, s)) % 2) == 1);
            done = 1'b1;
         end
         off += len;
      end
      return res;
   endfunction

   function automatic void model_reset();
      m_cur = 0; m_pend = 0; m_start = 0;
      m_jq = 1'b0; m_mq = 1'b0; m_oq = 1'b0;
   endfunction

   function automatic void model_step(input bit j, input bit m, input bit o, input bit mu);
      bit rj, rm, ro, bz;
      int r, r2;
      rj = j && !m_jq; rm = m && !m_mq; ro = o && !m_oq;
      m_jq = j; m_mq = m; m_oq = o;
      if (m_cur != 0 && (cyc - m_start) == dur(m_cur)) begin
         m_cur   = m_pend;
         m_pend  = 0;
         m_start = cyc;
      end
      r  = ro ? 3 : (rm ? 2 : (rj ? 1 : 0));
      r2 = (ro && rm) ? 2 : (((ro || rm) && rj) ? 1 : 0);
      if (r != 0) begin
         if (m_cur == 0) begin
            m_cur = r; m_start = cyc; m_pend = (r == 3) ? 0 : r2;
         end else if (r >= m_cur) begin
            m_cur = r; m_start = cyc;
            if (r == 3) m_pend = 0;
         end else if (r > m_pend) begin
            m_pend = r;
         end
      end
      bz = (m_cur != 0) && !mu && exp_buzz(m_cur, cyc - m_start);
      exp_q.push_back({m_cur != 0, 2'(m_cur), bz});
      cyc++;
   endfunction

   // scoreboard monitor
   initial begin
      run_len = 0; prev_snd = 2'd0;
      for (int i = 0; i < 4; i++) last_run[i] = 0;
      forever begin
         @(negedge clk);
         if (cur_snd == prev_snd) run_len++;
         else begin
            last_run[prev_snd] = run_len;
            prev_snd = cur_snd;
            run_len  = 1;
         end
         if (exp_q.size() > 0) begin
            want_v = exp_q.pop_front();
            got_v  = {busy, cur_snd, buzzer};
            total++;
            if (got_v !== want_v) begin
               bad++;
               $display("FAIL cycle_out t=%0t busy/cur/buzzer got=%0b/%0d/%0b want=%0b/%0d/%0b",
                        $time, got_v[3], got_v[2:1], got_v[0], want_v[3], want_v[2:1], want_v[0]);
            end
         end
      end
   end

   // driver tasks
   task automatic chk(input string nm, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, want);
      end
   endtask

   task automatic step(input bit j, input bit m, input bit o, input bit mu);
      jumping = j; milestone = m; over = o; mute = mu;
      @(posedge clk);
      model_step(j, m, o, mu);
      #1;
   endtask

   task automatic drive(input bit j, input bit m, input bit o, input bit mu, input int n);
      for (int i = 0; i < n; i++) step(j, m, o, mu);
   endtask

   task automatic do_reset(input int ncyc);
      jumping = 1'b0; milestone = 1'b0; over = 1'b0; mute = 1'b0;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_buzzer", int'(buzzer), 0);
      chk("rst_cur_snd", int'(cur_snd), 0);
      repeat (ncyc) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   // stimulus
   initial begin
      total = 0; bad = 0; cyc = 0;
      jumping = 1'b0; milestone = 1'b0; over = 1'b0; mute = 1'b0;
      rst = 1'b1;
      model_reset();
      #2;
      do_reset(3);

      // single JUMP from idle
      drive(1, 0, 0, 0, 10);
      drive(0, 0, 0, 0, 3690);
      chk("jump_len", last_run[1], 3572);

      // JUMP+MILE together, extra JUMP edges pend once, JUMP follows MILE, then retrigger
      drive(1, 1, 0, 0, 5);
      drive(0, 0, 0, 0, 100);
      drive(1, 0, 0, 0, 50);
      drive(0, 0, 0, 0, 50);
      drive(1, 0, 0, 0, 50);
      drive(0, 0, 0, 0, 29905);
      drive(1, 0, 0, 0, 20);
      drive(0, 0, 0, 0, 3700);
      chk("mile_len", last_run[2], 29160);
      chk("mile_then_idle", int'(busy), 0);

      // OVER preempts a JUMP in mid-segment; JUMP does not resume
      drive(1, 0, 0, 0, 5);
      drive(0, 0, 0, 0, 1495);
      drive(0, 0, 1, 0, 5);
      drive(0, 0, 0, 0, 14700);
      chk("over_len", last_run[3], 14478);
      chk("over_idle_cur", int'(cur_snd), 0);

      // mute during OVER, then reset mid-effect
      drive(0, 0, 1, 0, 5);
      drive(0, 0, 0, 0, 500);
      drive(0, 0, 0, 1, 2000);
      drive(0, 0, 0, 0, 300);
      do_reset(3);
      drive(0, 0, 0, 0, 300);
      chk("post_rst_idle", int'(busy), 0);

      // random event levels
      lv_j = 1'b0; lv_m = 1'b0; lv_o = 1'b0; lv_mu = 1'b0;
      for (int i = 0; i < 12000; i++) begin
         if ($urandom_range(0, 149) == 0)  lv_j  = ~lv_j;
         if ($urandom_range(0, 799) == 0)  lv_m  = ~lv_m;
         if ($urandom_range(0, 2999) == 0) lv_o  = ~lv_o;
         if ($urandom_range(0, 499) == 0)  lv_mu = ~lv_mu;
         step(lv_j, lv_m, lv_o, lv_mu);
      end
      drive(0, 0, 0, 0, 5);

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
